// File: rtl/msk_pkg.sv
// Shared constants and types for the MSK transmit chain stages.
package msk_pkg;

  localparam int unsigned MSK_FRAME_BITS = 32;
  localparam int unsigned MSK_PULSE_DLY  = 41;
  localparam int unsigned MSK_CNT_W      = 7;
  localparam logic        MSK_I_INIT     = 1'b1;
  localparam logic        MSK_Q_INIT     = 1'b0;

  // Registered serial-to-parallel outputs, packed in debug-bus order (pulse at LSB)
  typedef struct packed {
    logic q;
    logic i;
    logic valid;
    logic pulse;
  } s2p_sym_t;

endpackage

// File: rtl/msk_s2p_frm_if.sv
// Bit-stream input / rate-held I/Q output bundle of the MSK serial-to-parallel framer.
interface msk_s2p_frm_if
  import msk_pkg::*;
#(
  parameter int unsigned CNT_W = MSK_CNT_W
) ();

  logic             frame_pulse_in;
  logic             bit_valid_in;
  logic             bit_data_in;
  logic             s2p_pulse_out;
  logic             s2p_valid_out;
  logic             s2p_i_out;
  logic             s2p_q_out;
  logic [CNT_W-1:0] bit_cnt_out;
  logic             frame_done_out;
  logic             overrun_err_out;
  logic [63:0]      debug_signal;

  modport master (
    output frame_pulse_in, bit_valid_in, bit_data_in,
    input  s2p_pulse_out, s2p_valid_out, s2p_i_out, s2p_q_out,
    input  bit_cnt_out, frame_done_out, overrun_err_out, debug_signal
  );

  modport slave (
    input  frame_pulse_in, bit_valid_in, bit_data_in,
    output s2p_pulse_out, s2p_valid_out, s2p_i_out, s2p_q_out,
    output bit_cnt_out, frame_done_out, overrun_err_out, debug_signal
  );

endinterface

// File: rtl/msk_dly_line.sv
// Fixed-length shift-register pulse delay; output is high exactly DLY cycles after the input.
module msk_dly_line #(
  parameter int unsigned DLY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic pulse_dly
);

  logic [DLY-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DLY-2:0], pulse};
    end
  end

  assign pulse_dly = sr_q[DLY-1];

endmodule

// File: rtl/msk_s2p_frm.sv
// MSK differential encoder and serial-to-parallel splitter with internal frame counting,
// overrun detection and a re-timed frame pulse for the downstream modulator.
module msk_s2p_frm
  import msk_pkg::*;
#(
  parameter int unsigned FRAME_BITS = MSK_FRAME_BITS,
  parameter int unsigned CNT_W      = MSK_CNT_W,
  parameter int unsigned PULSE_DLY  = MSK_PULSE_DLY,
  parameter bit          DIFF_EN    = 1'b1,
  parameter logic        I_INIT     = MSK_I_INIT,
  parameter logic        Q_INIT     = MSK_Q_INIT
) (
  input logic           logic_clk_in,
  input logic           logic_rst_n_in,
  msk_s2p_frm_if.slave  s2p
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic [CNT_W-1:0] cnt_q;
  logic             enc_q;
  logic             v1_q;
  logic             done1_q;
  logic             ovr_q;
  logic             phase_q;
  logic             i_q;
  logic             q_q;
  logic             valid_q;
  logic             done_q;
  logic             pulse_dly;

  logic             frame_full_c;
  logic             bit_acc_c;
  logic             enc_ref_c;
  logic             enc_nxt_c;
  logic [CNT_W-1:0] cnt_base_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  s2p_sym_t         sym_c;

  // A pulse restarts the frame in the same cycle, so a coincident bit counts against the new frame
  assign frame_full_c = (cnt_q == FRAME_CNT);
  assign bit_acc_c    = s2p.bit_valid_in && (s2p.frame_pulse_in || !frame_full_c);
  assign enc_ref_c    = s2p.frame_pulse_in ? 1'b1 : enc_q;
  assign enc_nxt_c    = DIFF_EN ? ~(s2p.bit_data_in ^ enc_ref_c) : s2p.bit_data_in;
  assign cnt_base_c   = s2p.frame_pulse_in ? '0 : cnt_q;
  assign cnt_nxt_c    = cnt_base_c + CNT_W'(1);

  // Stage 1: bit acceptance, encoder state, frame counter and overrun flag
  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      cnt_q   <= '0;
      enc_q   <= 1'b1;
      v1_q    <= 1'b0;
      done1_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      v1_q    <= bit_acc_c;
      done1_q <= bit_acc_c && (cnt_nxt_c == FRAME_CNT);
      if (bit_acc_c) begin
        cnt_q <= cnt_nxt_c;
        enc_q <= enc_nxt_c;
      end else if (s2p.frame_pulse_in) begin
        cnt_q <= '0;
        enc_q <= 1'b1;
      end
      if (s2p.bit_valid_in && !s2p.frame_pulse_in && frame_full_c) begin
        ovr_q <= 1'b1;
      end
    end
  end

  // Stage 2: I/Q split; a frame pulse presets I/Q and discards the bit still in stage 1
  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      i_q     <= I_INIT;
      q_q     <= Q_INIT;
      phase_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (s2p.frame_pulse_in) begin
      i_q     <= I_INIT;
      q_q     <= Q_INIT;
      phase_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= v1_q;
      done_q  <= v1_q && done1_q;
      if (v1_q) begin
        if (phase_q) begin
          i_q <= enc_q;
        end else begin
          q_q <= enc_q;
        end
        phase_q <= ~phase_q;
      end
    end
  end

  msk_dly_line #(
    .DLY (PULSE_DLY)
  ) u_dly_line (
    .clk       (logic_clk_in),
    .rst_n     (logic_rst_n_in),
    .pulse     (s2p.frame_pulse_in),
    .pulse_dly (pulse_dly)
  );

  assign sym_c = '{q: q_q, i: i_q, valid: valid_q, pulse: pulse_dly};

  assign s2p.s2p_pulse_out   = pulse_dly;
  assign s2p.s2p_valid_out   = valid_q;
  assign s2p.s2p_i_out       = i_q;
  assign s2p.s2p_q_out       = q_q;
  assign s2p.bit_cnt_out     = cnt_q;
  assign s2p.frame_done_out  = done_q;
  assign s2p.overrun_err_out = ovr_q;
  assign s2p.debug_signal    = {54'd0, ovr_q, sym_c, phase_q, enc_q, v1_q,
                                s2p.bit_data_in, s2p.bit_valid_in};

endmodule

// File: tb/tb_msk_s2p_frm.sv
// Scoreboard bench for msk_s2p_frm: one instance with differential encoding, one pass-through.
module tb_msk_s2p_frm;
  import msk_pkg::*;

  localparam int FB  = 32;
  localparam int DLY = 41;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  msk_s2p_frm_if #(.CNT_W(7)) if1 ();
  msk_s2p_frm_if #(.CNT_W(7)) if0 ();

  msk_s2p_frm #(
    .FRAME_BITS(FB), .CNT_W(7), .PULSE_DLY(DLY), .DIFF_EN(1'b1), .I_INIT(1'b1), .Q_INIT(1'b0)
  ) u_dut1 (
    .logic_clk_in   (clk),
    .logic_rst_n_in (rst_n),
    .s2p            (if1)
  );

  msk_s2p_frm #(
    .FRAME_BITS(FB), .CNT_W(7), .PULSE_DLY(DLY), .DIFF_EN(1'b0), .I_INIT(1'b1), .Q_INIT(1'b0)
  ) u_dut0 (
    .logic_clk_in   (clk),
    .logic_rst_n_in (rst_n),
    .s2p            (if0)
  );

  typedef struct {
    int   cyc;
    logic i1;
    logic q1;
    logic i0;
    logic q0;
    logic done;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;

  logic m_d1, m_d0, m_ph, m_i1, m_q1, m_i0, m_q0;
  int   m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_d1  = 1'b1;
    m_d0  = 1'b1;
    m_ph  = 1'b0;
    m_i1  = 1'b1;
    m_q1  = 1'b0;
    m_i0  = 1'b1;
    m_q0  = 1'b0;
  endtask

  task automatic drive(input logic p, input logic v, input logic a);
    if1.frame_pulse_in = p; if1.bit_valid_in = v; if1.bit_data_in = a;
    if0.frame_pulse_in = p; if0.bit_valid_in = v; if0.bit_data_in = a;
  endtask

  // One clock of stimulus; the reference model and scoreboard advance alongside it
  task automatic step(input logic p, input logic v, input logic a);
    @(posedge clk);
    #1;
    drive(p, v, a);
    if (p) begin
      if (sb.size() > 0 && sb[$].cyc == cyc + 1) void'(sb.pop_back());
      model_reset();
    end
    if (v && m_cnt < FB) begin
      m_cnt++;
      m_d1 = ~(a ^ m_d1);
      m_d0 = a;
      if (m_ph) begin
        m_i1 = m_d1; m_i0 = m_d0;
      end else begin
        m_q1 = m_d1; m_q0 = m_d0;
      end
      m_ph = ~m_ph;
      sb.push_back('{cyc: cyc + 2, i1: m_i1, q1: m_q1, i0: m_i0, q0: m_q0, done: (m_cnt == FB)});
    end
  endtask

  task automatic wait_neg(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_at(input int n, input logic e);
    wait_neg(n);
    chk("dly_pulse_d1", 64'(if1.s2p_pulse_out), 64'(e));
    chk("dly_pulse_d0", 64'(if0.s2p_pulse_out), 64'(e));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (if1.s2p_valid_out || if0.s2p_valid_out) begin
        if (sb.size() == 0) begin
          chk("unexp_valid", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("lat",       64'(cyc),                 64'(e.cyc));
          chk("valid_d1",  64'(if1.s2p_valid_out),   64'd1);
          chk("valid_d0",  64'(if0.s2p_valid_out),   64'd1);
          chk("i_d1",      64'(if1.s2p_i_out),       64'(e.i1));
          chk("q_d1",      64'(if1.s2p_q_out),       64'(e.q1));
          chk("i_d0",      64'(if0.s2p_i_out),       64'(e.i0));
          chk("q_d0",      64'(if0.s2p_q_out),       64'(e.q0));
          chk("done_d1",   64'(if1.frame_done_out),  64'(e.done));
          chk("done_d0",   64'(if0.frame_done_out),  64'(e.done));
        end
      end else begin
        chk("done_idle", 64'({if1.frame_done_out, if0.frame_done_out}), 64'd0);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missing_valid", 64'(if1.s2p_valid_out), 64'd1);
        void'(sb.pop_front());
      end
      if (if1.frame_done_out) done_cnt++;
    end
  end

  logic [3:0] bits = 4'b1001;
  logic [3:0] t_i1 = 4'b1001;
  logic [3:0] t_q1 = 4'b1111;
  logic [3:0] t_i0 = 4'b1001;
  logic [3:0] t_q0 = 4'b0011;

  initial begin
    int t;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();

    // Reset values
    @(negedge clk);
    chk("rst_dbg_d1", if1.debug_signal, 64'h88);
    chk("rst_dbg_d0", if0.debug_signal, 64'h88);
    chk("rst_cnt",    64'(if1.bit_cnt_out), 64'd0);
    chk("rst_i",      64'(if1.s2p_i_out), 64'd1);
    chk("rst_q",      64'(if1.s2p_q_out), 64'd0);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Pulse delay: single pulse, then back-to-back pair
    while (cyc < 99) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pulse_at(140, 1'b0);
    pulse_at(141, 1'b1);
    pulse_at(142, 1'b0);
    while (cyc < 199) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pulse_at(240, 1'b0);
    pulse_at(241, 1'b1);
    pulse_at(242, 1'b1);
    pulse_at(243, 1'b0);

    // Bits 1,0,0,1 spaced five cycles, checked against fixed I/Q tables
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, bits[k]);
      t = cyc;
      step(1'b0, 1'b0, 1'b0);
      wait_neg(t + 2);
      chk("tbl_valid", 64'({if1.s2p_valid_out, if0.s2p_valid_out}), 64'h3);
      chk("tbl_i_d1",  64'(if1.s2p_i_out), 64'(t_i1[k]));
      chk("tbl_q_d1",  64'(if1.s2p_q_out), 64'(t_q1[k]));
      chk("tbl_i_d0",  64'(if0.s2p_i_out), 64'(t_i0[k]));
      chk("tbl_q_d0",  64'(if0.s2p_q_out), 64'(t_q0[k]));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // Full frame, then overrun
    done_cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < FB; k++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    chk("done_once",  64'(done_cnt), 64'd1);
    chk("cnt_full1",  64'(if1.bit_cnt_out), 64'd32);
    chk("cnt_full0",  64'(if0.bit_cnt_out), 64'd32);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    wait_neg(cyc);
    chk("ovr_d1",     64'(if1.overrun_err_out), 64'd1);
    chk("ovr_d0",     64'(if0.overrun_err_out), 64'd1);
    chk("ovr_iq_d1",  64'({if1.s2p_i_out, if1.s2p_q_out}), 64'({m_i1, m_q1}));
    chk("ovr_iq_d0",  64'({if0.s2p_i_out, if0.s2p_q_out}), 64'({m_i0, m_q0}));
    chk("ovr_cnt",    64'(if1.bit_cnt_out), 64'd32);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    wait_neg(cyc);
    chk("pulse_cnt",  64'(if1.bit_cnt_out), 64'd0);
    chk("pulse_ovr",  64'({if1.overrun_err_out, if0.overrun_err_out}), 64'h3);

    // Bit followed by a pulse is flushed; I/Q return to presets
    step(1'b0, 1'b1, 1'b1);
    t = cyc;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    wait_neg(t + 2);
    chk("flush_valid", 64'({if1.s2p_valid_out, if0.s2p_valid_out}), 64'd0);
    chk("flush_iq_d1", 64'({if1.s2p_i_out, if1.s2p_q_out}), 64'b10);
    chk("flush_iq_d0", 64'({if0.s2p_i_out, if0.s2p_q_out}), 64'b10);

    // Pulse coincident with a bit: first bit of the new frame
    step(1'b1, 1'b1, 1'b1);
    t = cyc;
    step(1'b0, 1'b0, 1'b0);
    wait_neg(t + 2);
    chk("coin_cnt",   64'(if1.bit_cnt_out), 64'd1);
    chk("coin_q_d1",  64'(if1.s2p_q_out), 64'd1);
    chk("coin_q_d0",  64'(if0.s2p_q_out), 64'd1);

    // Asynchronous reset mid-frame
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    sb.delete();
    model_reset();
    #1;
    chk("arst_dbg_d1", if1.debug_signal, 64'h88);
    chk("arst_dbg_d0", if0.debug_signal, 64'h88);
    chk("arst_cnt",    64'(if1.bit_cnt_out), 64'd0);
    chk("arst_done",   64'(if1.frame_done_out), 64'd0);
    chk("arst_ovr",    64'(if1.overrun_err_out), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, bits[k]);
      step(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    wait_neg(cyc);
    chk("resume_cnt", 64'(if1.bit_cnt_out), 64'd4);
    chk("resume_iq",  64'({if1.s2p_i_out, if1.s2p_q_out, if0.s2p_i_out, if0.s2p_q_out}), 64'b1110);
    chk("sb_empty",   64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
